// File: rtl/ws2812b_chain_capture.sv
// WS2812B chain receiver: captures the first NUM_PIXELS pixels of each frame into a
// readable byte buffer, then regenerates the rest of the stream on dout for the next LED.
module ws2812b_chain_capture #(
  parameter  int NUM_PIXELS      = 4,
  parameter  int BYTES_PER_PIXEL = 3,
  parameter  int CNT_W           = 16,
  localparam int TOTAL           = NUM_PIXELS * BYTES_PER_PIXEL,
  localparam int ADDR_W          = (TOTAL > 1) ? $clog2(TOTAL) : 1,
  localparam int BC_W            = $clog2(TOTAL + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  input  logic [CNT_W-1:0]  threshold_cycles,
  input  logic [CNT_W-1:0]  idle_ticks,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              clear_flags,
  output logic              frame_done,
  output logic              short_frame,
  output logic              busy,
  output logic              dout
);

  typedef enum logic {CAPTURE, FORWARD} state_e;

  state_e                  state_q, state_d;
  logic                    din_q;
  logic [CNT_W-1:0]        high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]        low_cnt_q, low_cnt_d;
  logic [BC_W-1:0]         byte_cnt_q, byte_cnt_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [6:0]              shreg_q, shreg_d;
  logic [TOTAL-1:0][7:0]   pix_buf_q, pix_buf_d;
  logic                    frame_done_q, frame_done_d;
  logic                    short_frame_q, short_frame_d;
  logic                    dout_q, dout_d;

  logic       bit_evt, bit_val, idle_evt, done_set, short_set;
  logic [7:0] new_byte;

  // Pulse width is measured on the registered copy, so the fall is seen one cycle early
  // on din itself and the bit is consumed in that same cycle.
  assign bit_evt  = din_q && !din;
  assign bit_val  = high_cnt_q > threshold_cycles;
  assign idle_evt = (idle_ticks != '0) && !din && (low_cnt_q == idle_ticks - CNT_W'(1));
  assign new_byte = {shreg_q, bit_val};

  always_comb begin
    high_cnt_d = din_q ? ((&high_cnt_q) ? high_cnt_q : high_cnt_q + CNT_W'(1)) : '0;
    low_cnt_d  = din   ? '0 : ((&low_cnt_q) ? low_cnt_q : low_cnt_q + CNT_W'(1));
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    pix_buf_d  = pix_buf_q;
    done_set   = 1'b0;
    short_set  = 1'b0;
    if (idle_evt) begin
      state_d    = CAPTURE;
      byte_cnt_d = '0;
      bit_cnt_d  = '0;
      short_set  = (state_q == CAPTURE) && (byte_cnt_q != '0);
    end else if (state_q == CAPTURE && bit_evt) begin
      if (bit_cnt_q == 3'd7) begin
        pix_buf_d[byte_cnt_q[ADDR_W-1:0]] = new_byte;
        bit_cnt_d  = '0;
        byte_cnt_d = byte_cnt_q + BC_W'(1);
        if (byte_cnt_q == BC_W'(TOTAL - 1)) begin
          done_set = 1'b1;
          state_d  = FORWARD;
        end
      end else begin
        shreg_d   = new_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end
  end

  // Flag set beats a coincident clear.
  assign frame_done_d  = done_set  | (frame_done_q  & ~clear_flags);
  assign short_frame_d = short_set | (short_frame_q & ~clear_flags);
  assign dout_d        = (state_q == FORWARD) && din;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CAPTURE;
      din_q         <= 1'b0;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      pix_buf_q     <= '0;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
      dout_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      din_q         <= din;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      pix_buf_q     <= pix_buf_d;
      frame_done_q  <= frame_done_d;
      short_frame_q <= short_frame_d;
      dout_q        <= dout_d;
    end
  end

  assign rd_data     = (int'(rd_addr) < TOTAL) ? pix_buf_q[rd_addr] : 8'h00;
  assign frame_done  = frame_done_q;
  assign short_frame = short_frame_q;
  assign busy        = (state_q == CAPTURE) && (byte_cnt_q != '0 || bit_cnt_q != '0);
  assign dout        = dout_q;

endmodule
